wm_pixel_sequencer: RTL and testbench

- Frame-level controller that feeds the soft watermark processor one pixel at a time.
- Fetches an image pixel and a watermark pixel from synchronous ROMs and holds them on the processor's pixel inputs.
- Waits until the processor's iteration counter advances, which marks one loop pass, then writes the processor's output pixel to the result framebuffer.
- Sits between the pixel/watermark ROMs, the processor, and the VGA framebuffer write port.

---
 rtl/wm_pixel_sequencer.sv | 112 +++++++++++
 tb/tb_wm_pixel_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wm_pixel_sequencer.sv
// Frame sequencer for the soft watermark processor: fetches one image/watermark
// pixel pair, waits for a processor loop pass, then writes the result pixel.
module wm_pixel_sequencer #(
  parameter int unsigned NUM_PIX     = 19200,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned SETTLE_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       img_rdata,
  input  logic [11:0]       wm_rdata,
  output logic [11:0]       proc_image_pix,
  output logic [11:0]       proc_water_pix,
  input  logic [11:0]       proc_regout,
  input  logic [11:0]       proc_index,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_wdata
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIX - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, READ, LATCH, WAIT_PROC, SETTLE, WRITE, NEXT, DONE, ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [11:0]       idx_ref;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = READ;
      READ:      state_d = LATCH;
      LATCH:     state_d = WAIT_PROC;
      // Inequality rather than magnitude so the 4095 -> 0 wrap counts as a pass.
      WAIT_PROC: begin
        if (proc_index != idx_ref)
          state_d = (SETTLE_CYC == 0) ? WRITE : SETTLE;
        else if (tmo_cnt == TMO_LAST)
          state_d = ERROR;
      end
      SETTLE:    if (settle_cnt == SET_LAST) state_d = WRITE;
      WRITE:     state_d = NEXT;
      NEXT:      state_d = (pix_cnt == LAST_PIX) ? DONE : READ;
      DONE:      state_d = IDLE;
      ERROR:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pix_cnt        <= '0;
      tmo_cnt        <= '0;
      settle_cnt     <= '0;
      idx_ref        <= '0;
      proc_image_pix <= '0;
      proc_water_pix <= '0;
      err            <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            pix_cnt <= '0;
            err     <= 1'b0;
          end
        end
        LATCH: begin
          proc_image_pix <= img_rdata;
          proc_water_pix <= wm_rdata;
          idx_ref        <= proc_index;
          tmo_cnt        <= '0;
        end
        WAIT_PROC: begin
          tmo_cnt    <= tmo_cnt + 1'b1;
          settle_cnt <= '0;
          if (state_d == ERROR) err <= 1'b1;
        end
        SETTLE: settle_cnt <= settle_cnt + 1'b1;
        NEXT:   if (pix_cnt != LAST_PIX) pix_cnt <= pix_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // The pixel counter doubles as both ROM read address and framebuffer address.
  always_comb begin
    busy     = !(state_q inside {IDLE, DONE, ERROR});
    done     = (state_q == DONE);
    fb_we    = (state_q == WRITE);
    rd_addr  = pix_cnt;
    fb_addr  = pix_cnt;
    fb_wdata = fb_we ? proc_regout : '0;
  end

endmodule

// File: tb/tb_wm_pixel_sequencer.sv
// Directed bench for wm_pixel_sequencer with ROM and processor models.
module tb_wm_pixel_sequencer;

  localparam int unsigned NUM_PIX     = 4;
  localparam int unsigned ADDR_W      = 15;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned SETTLE_CYC  = 2;

  logic              clk = 1'b0;
  logic              rst_n, start;
  logic              busy, done, err, fb_we;
  logic [ADDR_W-1:0] rd_addr, fb_addr;
  logic [11:0]       img_rdata, wm_rdata, proc_image_pix, proc_water_pix;
  logic [11:0]       proc_regout, proc_index, fb_wdata;

  always #5 clk = ~clk;

  wm_pixel_sequencer #(
    .NUM_PIX(NUM_PIX), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .rd_addr(rd_addr), .img_rdata(img_rdata), .wm_rdata(wm_rdata),
    .proc_image_pix(proc_image_pix), .proc_water_pix(proc_water_pix),
    .proc_regout(proc_regout), .proc_index(proc_index),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata)
  );

  // Synchronous ROMs, one cycle of latency.
  always @(posedge clk) begin
    img_rdata <= 12'h100 + 12'(rd_addr);
    wm_rdata  <= 12'h0F0;
  end

  // Processor model: one index bump per pixel, timed off busy rising or fb_we.
  int          cd = 0;
  int          bump_cnt = 0;
  int          bump_stop = 1000000;
  logic        busy_q = 1'b0;
  logic [11:0] idx_base = 12'h000;
  assign proc_index = idx_base + bump_cnt[11:0];

  always @(negedge clk) begin
    if (busy && !busy_q) cd = 4;
    else if (fb_we) cd = 6;
    else if (cd != 0) begin
      cd = cd - 1;
      if (cd == 0 && bump_cnt < bump_stop) bump_cnt = bump_cnt + 1;
    end
    busy_q      = busy;
    proc_regout = proc_image_pix | proc_water_pix;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned wr_addr_q[$], wr_data_q[$], wr_time_q[$];
  int          done_cnt = 0;
  always @(negedge clk) begin
    if (fb_we) begin
      wr_addr_q.push_back(32'(fb_addr));
      wr_data_q.push_back(32'(fb_wdata));
      wr_time_q.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (wr_addr_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wr_wait", 32'(wr_addr_q.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_wait", 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_frame(input int base);
    for (int i = 0; i < NUM_PIX; i++) begin
      chk("fb_addr", wr_addr_q[base+i], 32'(i));
      chk("fb_wdata", wr_data_q[base+i], 32'h1F0 + 32'(i));
    end
  endtask

  task automatic check_reset_outputs;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_img_pix", 32'(proc_image_pix), 32'd0);
    chk("rst_wm_pix", 32'(proc_water_pix), 32'd0);
    chk("rst_fb_wdata", 32'(fb_wdata), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int b, d;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal frame
    b = wr_addr_q.size(); d = done_cnt;
    pulse_start();
    chk("busy_on_start", 32'(busy), 32'd1);
    wait_done(d + 1, 200);
    repeat (5) @(negedge clk);
    chk("t1_writes", 32'(wr_addr_q.size() - b), 32'd4);
    check_frame(b);
    chk("t1_interval", wr_time_q[b+1] - wr_time_q[b], 32'd9);
    chk("t1_done", 32'(done_cnt - d), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_err", 32'(err), 32'd0);

    // Start pulsed while busy is ignored
    repeat (10) @(negedge clk);
    b = wr_addr_q.size(); d = done_cnt;
    pulse_start();
    wait_writes(b + 1, 50);
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done(d + 1, 200);
    repeat (30) @(negedge clk);
    chk("busy_start_writes", 32'(wr_addr_q.size() - b), 32'd4);
    check_frame(b);
    chk("busy_start_done", 32'(done_cnt - d), 32'd1);

    // proc_index wraps 0xFFF -> 0x000 during the first pass
    idx_base = 12'hFFF - bump_cnt[11:0];
    b = wr_addr_q.size(); d = done_cnt;
    pulse_start();
    wait_done(d + 1, 200);
    repeat (5) @(negedge clk);
    chk("wrap_writes", 32'(wr_addr_q.size() - b), 32'd4);
    check_frame(b);
    chk("wrap_err", 32'(err), 32'd0);

    // Processor stalls after pixel 0 (index stuck at 0x005)
    repeat (10) @(negedge clk);
    idx_base  = 12'h004 - bump_cnt[11:0];
    bump_stop = bump_cnt + 1;
    b = wr_addr_q.size(); d = done_cnt;
    pulse_start();
    wait_writes(b + 1, 50);
    wait_cyc(wr_time_q[b] + 19);
    chk("tmo_err_before", 32'(err), 32'd0);
    chk("tmo_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_img_hold", 32'(proc_image_pix), 32'h101);
    repeat (20) @(negedge clk);
    chk("tmo_writes", 32'(wr_addr_q.size() - b), 32'd1);
    chk("tmo_done", 32'(done_cnt - d), 32'd0);
    chk("tmo_err_sticky", 32'(err), 32'd1);

    // Start after error clears err and runs a full frame
    bump_stop = 1000000;
    b = wr_addr_q.size(); d = done_cnt;
    pulse_start();
    chk("err_clear", 32'(err), 32'd0);
    chk("err_restart_busy", 32'(busy), 32'd1);
    wait_done(d + 1, 200);
    repeat (5) @(negedge clk);
    chk("err_restart_writes", 32'(wr_addr_q.size() - b), 32'd4);
    check_frame(b);
    chk("err_restart_done", 32'(done_cnt - d), 32'd1);

    // Reset during SETTLE of pixel 2
    repeat (10) @(negedge clk);
    b = wr_addr_q.size(); d = done_cnt;
    pulse_start();
    wait_writes(b + 2, 100);
    wait_cyc(wr_time_q[b+1] + 7);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_mid_writes", 32'(wr_addr_q.size() - b), 32'd2);
    chk("rst_mid_done", 32'(done_cnt - d), 32'd0);
    b = wr_addr_q.size(); d = done_cnt;
    pulse_start();
    wait_done(d + 1, 200);
    repeat (5) @(negedge clk);
    chk("rst_restart_writes", 32'(wr_addr_q.size() - b), 32'd4);
    check_frame(b);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
